logic_sweep_unit: RTL and testbench
===================================

LOGIC_SWEEP_UNIT -- requirements
Module: logic_sweep_unit

Interface
REQ-001 Parameter N_IN, default 3, number of function inputs; legal range 2..6.
REQ-002 Parameter TW, default 2^N_IN, truth-table width (derived; not overridden).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 clear  input  1  synchronous abort; returns to IDLE, no done.
REQ-007 mode  input  2  function select: 0 majority, 1 parity, 2 all-AND, 3 threshold.
REQ-008 thr  input  clog2(N_IN+1)  threshold for mode 3 (popcount >= thr).
REQ-009 busy  output  1  high while in SWEEP.
REQ-010 done  output  1  one-cycle pulse when sweep completes.
REQ-011 vec  output  N_IN  input combination currently being evaluated.
REQ-012 f_out  output  1  function value for vec (combinational from vec, latched mode/thr).
REQ-013 truth_table  output  TW  bit i = function value of combination i.
REQ-014 ones_cnt  output  N_IN+1  number of 1 bits captured in truth_table.

Function
REQ-015 FSM states IDLE, SWEEP, DONE; SHALL be in IDLE after reset.
REQ-016 IDLE & start & !clear: latch mode and thr, clear truth_table and ones_cnt, vec<=0, go SWEEP.
REQ-017 Mode and thr SHALL be taken from latched copies during a sweep; input changes mid-sweep have no effect.
REQ-018 SWEEP, each edge: truth_table[vec]<=f_out, ones_cnt+=f_out, vec<=vec+1.
REQ-019 SWEEP with vec=TW-1: capture last bit, vec wraps to 0, go DONE.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; truth_table and ones_cnt hold until next start.
REQ-021 Latency: start sampled at edge k -> done high in the cycle after edge k+TW (TW+1 edges).
REQ-022 Majority: f=1 iff popcount(vec) > N_IN/2 (integer division).
REQ-023 Parity: f = XOR of all vec bits. All-AND: f = AND of all vec bits.
REQ-024 Threshold: f=1 iff popcount(vec) >= thr; thr=0 gives all ones; thr>N_IN gives all zeros.
REQ-025 start while busy or in DONE SHALL be ignored (no restart, no queueing).
REQ-026 clear in SWEEP or DONE: next state IDLE, vec<=0, done not asserted; truth_table/ones_cnt keep partial values.
REQ-027 start and clear together in IDLE: clear wins, remain IDLE.
REQ-028 busy SHALL be 1 exactly in SWEEP; done and busy never high together.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, busy=0, done=0, vec=0, truth_table=0, ones_cnt=0, latched mode=0, thr=0.
REQ-030 Reset mid-sweep SHALL abandon the sweep; no done pulse after release.
REQ-031 First start SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-032 Shared package SHALL hold mode encodings (MODE_MAJ, MODE_PAR, MODE_AND, MODE_THR) and FSM state encodings.
REQ-033 Function evaluation SHALL be a separate combinational sub-module logic_eval (inputs vec, mode, thr; output f).
REQ-034 Sequential FSM, counter and capture registers SHALL reside in logic_sweep_unit.

Verification
REQ-035 N_IN=3, mode 0, start -> truth_table=8'hE8, ones_cnt=4, done pulse in the cycle after edge 8 following start.
REQ-036 N_IN=3, mode 1 -> 8'h96, ones_cnt=4; mode 2 -> 8'h80, ones_cnt=1.
REQ-037 N_IN=3, mode 3, thr=0 -> 8'hFF, ones_cnt=8; thr=2 -> 8'hE8; thr=3 -> 8'h80.
REQ-038 mode 0 sweep; change mode to 1 and pulse start at vec=3 -> result still 8'hE8, single done pulse.
REQ-039 clear at vec=4 -> IDLE next cycle, no done, truth_table=8'h08 (bits 0..3 of majority captured).
REQ-040 rst_n low at vec=5 -> all outputs zero immediately; after release, start with N_IN=4, mode 1 -> 16'h6996, ones_cnt=8.

Source files
------------

// File: rtl/logic_sweep_unit_pkg.sv
// Shared encodings for the truth-table sweep unit.
// Function-select codes and sweep FSM states.
package logic_sweep_unit_pkg;

    localparam logic [1:0] MODE_MAJ = 2'd0;
    localparam logic [1:0] MODE_PAR = 2'd1;
    localparam logic [1:0] MODE_AND = 2'd2;
    localparam logic [1:0] MODE_THR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/logic_sweep_unit_eval.sv
// Combinational boolean function evaluator.
// Computes majority/parity/AND/threshold of one input vector.
module logic_eval
    import logic_sweep_unit_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int TH_W = $clog2(N_IN + 1)
) (
    input  logic [N_IN-1:0] vec,
    input  logic [1:0]      mode,
    input  logic [TH_W-1:0] thr,
    output logic            f
);

    localparam logic [7:0] HALF = 8'(N_IN / 2);

    logic [7:0] pc;

    // popcount of vec, then select the requested function
    always_comb begin
        pc = '0;
        for (int i = 0; i < N_IN; i++) begin
            pc = pc + 8'(vec[i]);
        end
        f = 1'b0;
        unique case (mode)
            MODE_MAJ: f = (pc > HALF);
            MODE_PAR: f = ^vec;
            MODE_AND: f = &vec;
            MODE_THR: f = (pc >= 8'(thr));
            default:  f = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_sweep_unit.sv
// Truth-table sweep unit: steps vec through every input
// combination and captures the selected function's value.
module logic_sweep_unit
    import logic_sweep_unit_pkg::*;
#(
    parameter int N_IN = 3,
    parameter int TW   = 2 ** N_IN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       clear,
    input  logic [1:0]                 mode,
    input  logic [$clog2(N_IN+1)-1:0]  thr,
    output logic                       busy,
    output logic                       done,
    output logic [N_IN-1:0]            vec,
    output logic                       f_out,
    output logic [TW-1:0]              truth_table,
    output logic [N_IN:0]              ones_cnt
);

    localparam int TH_W = $clog2(N_IN + 1);
    localparam int CW   = N_IN + 1;

    state_t          state;
    logic [1:0]      mode_q;
    logic [TH_W-1:0] thr_q;

    logic_eval #(
        .N_IN (N_IN),
        .TH_W (TH_W)
    ) u_eval (
        .vec  (vec),
        .mode (mode_q),
        .thr  (thr_q),
        .f    (f_out)
    );

    // FSM, vector counter and truth-table capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            vec         <= '0;
            truth_table <= '0;
            ones_cnt    <= '0;
            mode_q      <= '0;
            thr_q       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start && !clear) begin
                        mode_q      <= mode;
                        thr_q       <= thr;
                        truth_table <= '0;
                        ones_cnt    <= '0;
                        vec         <= '0;
                        busy        <= 1'b1;
                        state       <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (clear) begin
                        vec   <= '0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        truth_table[vec] <= f_out;
                        ones_cnt <= ones_cnt + CW'(f_out);
                        vec      <= vec + 1'b1;
                        if (&vec) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    vec   <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_unit.sv
// Directed bench for logic_sweep_unit (N_IN=3 and N_IN=4).
// Expected truth tables are hand-computed constants.
module tb_logic_sweep_unit;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [1:0]  mode;
    logic        start3;
    logic [1:0]  thr3;
    logic        busy3, done3, f3;
    logic [2:0]  vec3;
    logic [7:0]  tt3;
    logic [3:0]  cnt3;
    logic        start4;
    logic [2:0]  thr4;
    logic        busy4, done4, f4;
    logic [3:0]  vec4;
    logic [15:0] tt4;
    logic [4:0]  cnt4;

    int checks = 0;
    int errors = 0;
    int lat;
    int pulses;
    int ovl;
    int found;

    logic_sweep_unit #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .clear(clear),
        .mode(mode), .thr(thr3), .busy(busy3), .done(done3),
        .vec(vec3), .f_out(f3), .truth_table(tt3), .ones_cnt(cnt3)
    );

    logic_sweep_unit #(.N_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .clear(clear),
        .mode(mode), .thr(thr4), .busy(busy4), .done(done4),
        .vec(vec4), .f_out(f4), .truth_table(tt4), .ones_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input bit sel, input logic [1:0] m,
                      input logic [2:0] t);
        mode = m;
        if (sel) begin thr4 = t; start4 = 1'b1; end
        else begin thr3 = t[1:0]; start3 = 1'b1; end
        @(posedge clk); #1;
        start3 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic watch(input bit sel, input int cyc);
        logic d, b;
        lat = -1; pulses = 0; ovl = 0;
        for (int i = 1; i <= cyc; i++) begin
            @(posedge clk); #1;
            d = sel ? done4 : done3;
            b = sel ? busy4 : busy3;
            if (d) begin
                pulses++;
                if (lat < 0) lat = i;
            end
            if (d && b) ovl = 1;
        end
    endtask

    task automatic reach3(input logic [2:0] v);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (vec3 == v && busy3) begin
                found = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("reach_vec", found, 1);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; mode = 2'd0;
        start3 = 1'b0; start4 = 1'b0; thr3 = '0; thr4 = '0;
        #12;
        chk("rst_busy", busy3, 0);
        chk("rst_done", done3, 0);
        chk("rst_vec", vec3, 0);
        chk("rst_tt", tt3, 0);
        chk("rst_cnt", cnt3, 0);
        chk("rst_tt4", tt4, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        go(0, 2'd0, 3'd0);
        chk("maj_busy", busy3, 1);
        watch(0, 30);
        chk("maj_lat", lat, 8);
        chk("maj_pulses", pulses, 1);
        chk("maj_ovl", ovl, 0);
        chk("maj_tt", tt3, 8'hE8);
        chk("maj_cnt", cnt3, 4);

        go(0, 2'd1, 3'd0);
        watch(0, 20);
        chk("par_tt", tt3, 8'h96);
        chk("par_cnt", cnt3, 4);
        go(0, 2'd2, 3'd0);
        watch(0, 20);
        chk("and_tt", tt3, 8'h80);
        chk("and_cnt", cnt3, 1);
        go(0, 2'd3, 3'd0);
        watch(0, 20);
        chk("thr0_tt", tt3, 8'hFF);
        chk("thr0_cnt", cnt3, 8);
        go(0, 2'd3, 3'd2);
        watch(0, 20);
        chk("thr2_tt", tt3, 8'hE8);
        go(0, 2'd3, 3'd3);
        watch(0, 20);
        chk("thr3_tt", tt3, 8'h80);
        chk("thr3_cnt", cnt3, 1);

        go(0, 2'd0, 3'd0);
        reach3(3'd3);
        chk("mid_f", f3, 1);
        mode = 2'd1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        watch(0, 25);
        chk("ign_pulses", pulses, 1);
        chk("ign_tt", tt3, 8'hE8);

        go(0, 2'd0, 3'd0);
        reach3(3'd4);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_busy", busy3, 0);
        chk("clr_vec", vec3, 0);
        watch(0, 12);
        chk("clr_pulses", pulses, 0);
        chk("clr_tt", tt3, 8'h08);
        chk("clr_cnt", cnt3, 1);

        mode = 2'd1; start3 = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0; clear = 1'b0;
        chk("sc_busy", busy3, 0);
        chk("sc_tt", tt3, 8'h08);

        go(0, 2'd0, 3'd0);
        reach3(3'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy3, 0);
        chk("arst_vec", vec3, 0);
        chk("arst_tt", tt3, 0);
        chk("arst_cnt", cnt3, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        watch(0, 12);
        chk("arst_pulses", pulses, 0);

        go(1, 2'd1, 3'd0);
        watch(1, 30);
        chk("n4_lat", lat, 16);
        chk("n4_pulses", pulses, 1);
        chk("n4_tt", tt4, 16'h6996);
        chk("n4_cnt", cnt4, 8);

        go(1, 2'd3, 3'd5);
        watch(1, 30);
        chk("n4_thr5_tt", tt4, 16'h0000);
        chk("n4_thr5_cnt", cnt4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
